// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: sequencer states and
// the clock-edge numbering of a host-to-device frame.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RX,
      INHIBIT,
      RTS,
      SHIFT,
      ACK_WAIT,
      DONE
   } ps2_tx_state_t;

   localparam int FRAME_CLOCKS = 11;
   localparam int PARITY_EDGE  = 9;
   localparam int STOP_EDGE    = 10;
   localparam int ACK_EDGE     = 11;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Metastability synchroniser for one raw PS/2 pin plus a one-cycle pulse on
// each falling edge of the synchronised level.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_s,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_p;
   logic                   line_prev;

   // Idle PS/2 lines float high, so resetting to 1 avoids a false edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p    <= '1;
         line_prev <= 1'b1;
      end else begin
         sync_p    <= {sync_p[SYNC_STAGES-2:0], line_in};
         line_prev <= sync_p[SYNC_STAGES-1];
      end
   end

   assign line_s = sync_p[SYNC_STAGES-1];
   assign fall   = line_prev & ~line_s;

endmodule

// File: rtl/ps2_host_tx_ctrl.sv
// Host-to-device PS/2 command sequencer: waits out any receive frame, inhibits
// the clock, requests to send, shifts the byte out and reports ACK/NACK/timeout.
module ps2_host_tx_ctrl
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 1000,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       rx_active,
   output logic       rx_hold,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err_nack,
   output logic       err_timeout
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    state, state_n;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [3:0]       bit_cnt, bit_cnt_n, edge_no;
   logic [7:0]       tx_byte;
   logic             tx_parity;
   logic             ack_seen, ack_seen_n;
   logic             data_oe_n, timed_out, timed_state, accept;
   logic             clk_s, clk_fall, data_s, data_fall_unused;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clk(clk), .rst(rst), .line_in(ps2_clk_in), .line_s(clk_s), .fall(clk_fall)
   );

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
      .clk(clk), .rst(rst), .line_in(ps2_data_in), .line_s(data_s), .fall(data_fall_unused)
   );

   assign accept      = cmd_valid && cmd_ready;
   assign timed_state = (state == RTS) || (state == SHIFT) || (state == ACK_WAIT);
   assign edge_no     = bit_cnt + 4'd1;

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      ack_seen_n = ack_seen;
      data_oe_n  = ps2_data_oe;
      timed_out  = 1'b0;
      if (timed_state && (to_cnt == TO_LAST)) begin
         // A stalled device must never wedge the port, even mid-edge.
         state_n   = DONE;
         timed_out = 1'b1;
      end else begin
         unique case (state)
            IDLE:     if (accept) state_n = WAIT_RX;
            WAIT_RX:  if (!rx_active) state_n = INHIBIT;
            INHIBIT:  if (inh_cnt == INH_LAST) begin
                         state_n   = RTS;
                         bit_cnt_n = '0;
                         data_oe_n = 1'b1;
                      end
            RTS:      state_n = SHIFT;
            SHIFT:    if (clk_fall) begin
                         bit_cnt_n = edge_no;
                         if (edge_no < 4'(PARITY_EDGE)) data_oe_n = ~tx_byte[bit_cnt[2:0]];
                         else if (edge_no == 4'(PARITY_EDGE)) data_oe_n = ~tx_parity;
                         else if (edge_no == 4'(STOP_EDGE)) data_oe_n = 1'b0;
                         else if (edge_no == 4'(ACK_EDGE)) begin
                            ack_seen_n = ~data_s;
                            state_n    = ACK_WAIT;
                         end
                      end
            ACK_WAIT: if (clk_s && data_s) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
         endcase
      end
      if ((state_n != RTS) && (state_n != SHIFT)) data_oe_n = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         bit_cnt     <= '0;
         ack_seen    <= 1'b0;
         cmd_ready   <= 1'b1;
         rx_hold     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         err_nack    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         ack_seen    <= ack_seen_n;
         inh_cnt     <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
         to_cnt      <= timed_state ? to_cnt + 1'b1 : '0;
         cmd_ready   <= (state_n == IDLE);
         busy        <= (state_n != IDLE);
         rx_hold     <= (state_n != IDLE) && (state_n != WAIT_RX);
         ps2_clk_oe  <= (state_n == INHIBIT);
         ps2_data_oe <= data_oe_n;
         done        <= (state_n == DONE);
         // Status flags persist until the next command is taken.
         if (accept) begin
            ack_ok      <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
         end else if (state_n == DONE) begin
            ack_ok      <= ~timed_out & ack_seen;
            err_nack    <= ~timed_out & ~ack_seen;
            err_timeout <= timed_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         tx_byte   <= cmd_data;
         tx_parity <= odd_parity(cmd_data);
      end
   end

endmodule
